dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data-memory port. Accepts one load/store request at a time
//  over a valid/ready handshake and returns a one-cycle response after a fixed latency.
//  Handles byte/half/word sizes: byte-lane steering, write strobes and alignment/range errors.
//  Sits between the core's load/store path and a word-organised on-chip RAM.
// PARAMETERS
//  ADDR_WIDTH   32    byte-address width of req_addr
//  DEPTH_WORDS  1024  number of 32-bit words in the RAM (byte range 0 .. 4*DEPTH_WORDS-1)
//  LATENCY      2     cycles from acceptance to resp_valid; legal range >= 1
// PORTS
//  clk         in   1           single clock, all state on rising edge
//  rst         in   1           synchronous, active-high reset
//  req_valid   in   1           request present
//  req_ready   out  1           responder can accept (1 only in IDLE)
//  req_write   in   1           1 = store, 0 = load
//  req_addr    in   ADDR_WIDTH  byte address
//  req_size    in   2           00 byte, 01 half, 10 word, 11 illegal (= func3[1:0])
//  req_wdata   in   32          store data, LSB-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1           one-cycle response pulse, no backpressure
//  resp_rdata  out  32          load data, LSB-justified, unused upper bits 0; 0 for stores/errors
//  resp_err    out  1           valid with resp_valid: misaligned, out-of-range or illegal size
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. RAM contents not reset.
//  - FSM: IDLE -> (LATENCY>1 ? WAIT : RESP) on accept (req_valid & req_ready).
//    WAIT holds LATENCY-1 cycles (down-counter), then RESP. RESP lasts 1 cycle, then IDLE.
//  - Timing: accept at the edge ending cycle T; resp_valid=1 during cycle T+LATENCY only.
//  - Throughput: one request per LATENCY+1 cycles. req_ready=0 in WAIT and RESP.
//    req_valid in those states is ignored and is not queued.
//  - Request fields are latched at accept; later changes on req_* have no effect.
//  - Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0;
//    addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS. On error: no RAM access, resp_err=1, resp_rdata=0.
//  - Store: strobes from size/addr[1:0]:
//      byte = 4'b0001 << addr[1:0]
//      half = 4'b0011 << addr[1:0]
//      word = 4'b1111
//    Data is replicated/shifted to the selected lanes. RAM is written on the accept edge, only on strobed bytes.
//  - Load: word read at the accept edge, so a store accepted earlier is always visible.
//    The selected byte/half is shifted right by 8*addr[1:0] and zero-extended. Sign extension is done by the core.
//  - Outside RESP: resp_rdata=0, resp_err=0.
//  - Reset mid-operation: pending response discarded, state IDLE next cycle.
//    A store already accepted stays committed. No resp_valid is emitted for the discarded request.
//  - rst has priority over an accept in the same cycle: the request is not taken and no write occurs.
// TESTING (LATENCY=2, DEPTH_WORDS=1024)
//  1. Word store 0xDEADBEEF @0x10, then word load @0x10:
//     resp_valid exactly 2 cycles after each accept; load rdata=0xDEADBEEF, err=0.
//  2. Byte store 0xAA @0x13, then word load @0x10: rdata=0xAADEADBEEF's lanes, i.e. 0xAAADBEEF.
//     Byte load @0x13 returns 0x000000AA.
//  3. Half store 0x1234 @0x12, then half load @0x12 -> 0x00001234.
//     Word load @0x10 -> 0x1234BEEF (after test 1).
//  4. Half load @0x11, word store @0x22, size=11 @0x0, load @0x1000:
//     each gives resp_err=1, rdata=0; RAM unchanged (re-read @0x20 -> prior value).
//  5. Hold req_valid high continuously:
//     req_ready pattern 1,0,0,1 repeating; exactly one resp_valid per accept.
//  6. Assert rst in the WAIT cycle of a store 0x55 @0x4:
//     no resp_valid, req_ready=1 next cycle; later word load @0x4 returns 0x55.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed response latency, byte-lane steering
// and alignment/range checking in front of a word-organised RAM.
//
// state  | meaning
// S_IDLE | ready; an accept performs the RAM access and latches the response
// S_WAIT | latency down-counter running, new requests ignored
// S_RESP | response presented for exactly one cycle
module dmem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_misalign;
    logic             w_range_err;
    logic             w_err;
    logic             w_do_write;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_off;
    logic [3:0]       w_strb;
    logic [31:0]      w_wlanes;
    logic [31:0]      w_rword;
    logic [31:0]      w_shift;
    logic [31:0]      w_load;

    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_off       = req_addr[1:0];
    assign w_idx       = req_addr[IDX_W+1:2];
    assign w_range_err = (req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);
    assign w_err       = w_misalign || w_range_err;
    assign w_do_write  = w_accept && req_write && !w_err && !rst;
    assign w_rword     = r_mem[w_idx];
    assign w_shift     = w_rword >> {w_off, 3'b000};

    // Size decode: strobes and replicated store lanes, plus the zero-extended load slice.
    always_comb begin
        w_misalign = 1'b0;
        w_strb     = 4'b0000;
        w_wlanes   = req_wdata;
        w_load     = w_shift;
        case (req_size)
            2'b00: begin
                w_strb   = 4'b0001 << w_off;
                w_wlanes = {4{req_wdata[7:0]}};
                w_load   = {24'h0, w_shift[7:0]};
            end
            2'b01: begin
                w_misalign = w_off[0];
                w_strb     = 4'b0011 << w_off;
                w_wlanes   = {2{req_wdata[15:0]}};
                w_load     = {16'h0, w_shift[15:0]};
            end
            2'b10: begin
                w_misalign = (w_off != 2'b00);
                w_strb     = 4'b1111;
            end
            default: w_misalign = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= CNT_W'(LATENCY - 1);
                r_err   <= w_err;
                r_rdata <= (w_err || req_write) ? 32'h0 : w_load;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (LATENCY > 1) ? S_WAIT : S_RESP;
            S_WAIT:  if (r_cnt == CNT_W'(1)) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        resp_valid = (r_state == S_RESP);
        resp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
        resp_err   = (r_state == S_RESP) && r_err;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed lane/error/reset scenarios plus randomized traffic
// checked against a byte-array memory model.
module tb_dmem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0]  m_mem [0:4*DEPTH-1];
    logic [31:0] m_rd;
    logic        m_er;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic [31:0] erd;
        bit          eer;
    } vec_t;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [1:0] sz, logic [31:0] wd,
                                logic [31:0] erd, bit eer);
        vec_t v;
        v.wr = wr; v.a = a; v.sz = sz; v.wd = wd; v.erd = erd; v.eer = eer;
        return v;
    endfunction

    // Reference: memory as a flat byte array; an access touches 2**size consecutive bytes.
    function automatic void model_apply(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                                        input logic [31:0] wd, output logic [31:0] erd,
                                        output logic eer);
        int nb;
        nb  = 1 << sz;
        erd = 32'h0;
        eer = (sz == 2'b11) || ((a % nb) != 0) || (a >= 4 * DEPTH);
        if (!eer) begin
            for (int i = 0; i < nb; i++) begin
                if (wr) m_mem[a + i] = wd[8*i +: 8];
                else    erd |= 32'(m_mem[a + i]) << (8 * i);
            end
        end
    endfunction

    // Drives one request from IDLE, scrambles req_* after accept, and watches the response window.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int np, output bit dirty);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_size  = 2'($urandom);
        req_wdata = $urandom;
        rd = 'x; er = 1'bx; lat = -1; np = 0; dirty = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                np++;
                if (lat < 0) begin
                    lat = k; rd = resp_rdata; er = resp_err;
                end
            end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
                dirty = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
        req_size = 2'b10; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_lanes();
        vec_t tbl[$];
        logic [31:0] rd; logic er; int lat; int np; bit dirty;
        tbl.push_back(mk(1, 32'h10, 2'b10, 32'hDEAD_BEEF, 32'h0,         0));
        tbl.push_back(mk(0, 32'h10, 2'b10, 32'h0,         32'hDEAD_BEEF, 0));
        tbl.push_back(mk(1, 32'h13, 2'b00, 32'h1234_56AA, 32'h0,         0));
        tbl.push_back(mk(0, 32'h10, 2'b10, 32'h0,         32'hAAAD_BEEF, 0));
        tbl.push_back(mk(0, 32'h13, 2'b00, 32'h0,         32'h0000_00AA, 0));
        tbl.push_back(mk(1, 32'h12, 2'b01, 32'hFFFF_1234, 32'h0,         0));
        tbl.push_back(mk(0, 32'h12, 2'b01, 32'h0,         32'h0000_1234, 0));
        tbl.push_back(mk(0, 32'h10, 2'b10, 32'h0,         32'h1234_BEEF, 0));
        tbl.push_back(mk(0, 32'h11, 2'b00, 32'h0,         32'h0000_00BE, 0));
        tbl.push_back(mk(1, 32'hFFC, 2'b10, 32'hCAFE_F00D, 32'h0,        0));
        tbl.push_back(mk(0, 32'hFFF, 2'b00, 32'h0,        32'h0000_00CA, 0));
        foreach (tbl[i]) begin
            do_req(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, er, lat, np, dirty);
            model_apply(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, m_rd, m_er);
            n_vec++;
            if (lat !== LAT || np !== 1 || dirty || rd !== tbl[i].erd || er !== tbl[i].eer) begin
                n_fail++;
                $display("FAIL lanes[%0d]: got lat=%0d pulses=%0d dirty=%0b rdata=%h err=%b, want lat=%0d pulses=1 dirty=0 rdata=%h err=%b",
                         i, lat, np, dirty, rd, er, LAT, tbl[i].erd, tbl[i].eer);
            end
        end
    endtask

    task automatic test_errors();
        vec_t tbl[$];
        logic [31:0] rd; logic er; int lat; int np; bit dirty;
        tbl.push_back(mk(1, 32'h20,   2'b10, 32'h600D_F00D, 32'h0, 0));
        tbl.push_back(mk(0, 32'h11,   2'b01, 32'h0,         32'h0, 1));
        tbl.push_back(mk(1, 32'h22,   2'b10, 32'hFFFF_FFFF, 32'h0, 1));
        tbl.push_back(mk(1, 32'h21,   2'b01, 32'hFFFF_FFFF, 32'h0, 1));
        tbl.push_back(mk(0, 32'h0,    2'b11, 32'h0,         32'h0, 1));
        tbl.push_back(mk(1, 32'h20,   2'b11, 32'h1111_1111, 32'h0, 1));
        tbl.push_back(mk(0, 32'h1000, 2'b10, 32'h0,         32'h0, 1));
        tbl.push_back(mk(1, 32'h1000, 2'b00, 32'h0000_0077, 32'h0, 1));
        tbl.push_back(mk(0, 32'h20,   2'b10, 32'h0,         32'h600D_F00D, 0));
        foreach (tbl[i]) begin
            do_req(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, rd, er, lat, np, dirty);
            model_apply(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, m_rd, m_er);
            n_vec++;
            if (lat !== LAT || np !== 1 || dirty || rd !== tbl[i].erd || er !== tbl[i].eer) begin
                n_fail++;
                $display("FAIL errors[%0d]: got lat=%0d pulses=%0d dirty=%0b rdata=%h err=%b, want lat=%0d pulses=1 dirty=0 rdata=%h err=%b",
                         i, lat, np, dirty, rd, er, LAT, tbl[i].erd, tbl[i].eer);
            end
        end
    endtask

    task automatic test_back_to_back();
        int np = 0;
        int bad = 0;
        model_apply(1'b0, 32'h10, 2'b10, 32'h0, m_rd, m_er);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_wdata = 32'h0;
        for (int c = 0; c < 12; c++) begin
            n_vec++;
            if (req_ready !== ((c % 3) == 0)) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b want %b", c, req_ready, ((c % 3) == 0));
            end
            if (resp_valid) begin
                np++;
                if (resp_rdata !== m_rd || resp_err !== 1'b0) bad++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) np++;
        end
        n_vec++;
        if (np !== 4 || bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_pulses: got pulses=%0d bad_data=%0d, want pulses=4 bad_data=0", np, bad);
        end
    endtask

    task automatic test_reset_mid();
        int np = 0;
        logic [31:0] rd; logic er; int lat; int npl; bit dirty;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_size = 2'b10; req_wdata = 32'h55;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model_apply(1'b1, 32'h4, 2'b10, 32'h55, m_rd, m_er);
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_wait_ready: got %b want 0", req_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) np++;
        end
        n_vec++;
        if (np !== 0) begin
            n_fail++;
            $display("FAIL rstmid_no_resp: got %0d pulses want 0", np);
        end
        // A store presented while rst is high must not be taken.
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4;
        req_size = 2'b10; req_wdata = 32'h77;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_prio_state: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
        do_req(1'b0, 32'h4, 2'b10, 32'h0, rd, er, lat, npl, dirty);
        n_vec++;
        if (lat !== LAT || npl !== 1 || rd !== 32'h55 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_committed_load: got lat=%0d pulses=%0d rdata=%h err=%b, want lat=%0d pulses=1 rdata=00000055 err=0",
                     lat, npl, rd, er, LAT);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; int np; bit dirty;
        logic [31:0] a; logic [31:0] wd; logic [1:0] sz; bit wr;
        for (int n = 0; n < 216; n++) begin
            if (n < 16) begin
                wr = 1'b1; sz = 2'b10; a = 32'(4 * n); wd = $urandom;
            end else begin
                wr = 1'($urandom);
                sz = 2'($urandom);
                wd = $urandom;
                a  = (($urandom % 8) == 0) ? $urandom_range(32'hFFFF_FFFF, 32'h1000)
                                           : 32'($urandom % 64);
            end
            do_req(wr, a, sz, wd, rd, er, lat, np, dirty);
            model_apply(wr, a, sz, wd, m_rd, m_er);
            n_vec++;
            if (lat !== LAT || np !== 1 || dirty || rd !== m_rd || er !== m_er) begin
                n_fail++;
                $display("FAIL random[%0d] wr=%0b a=%h sz=%0d: got lat=%0d pulses=%0d dirty=%0b rdata=%h err=%b, want lat=%0d pulses=1 dirty=0 rdata=%h err=%b",
                         n, wr, a, sz, lat, np, dirty, rd, er, LAT, m_rd, m_er);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_size = 2'b00; req_wdata = 32'h0;
        test_reset();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
